// File: rtl/mul_ns_pipe.sv
// Signed WIDTHxWIDTH multiplier with per-beat exact/approximate mode, STAGES-deep pipeline.
// Latency: STAGES cycles from acceptance to out_valid; one beat per cycle when unstalled.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready combinationally.
module mul_ns_pipe #(
    parameter int WIDTH    = 8,
    parameter int STAGES   = 2,
    parameter int APPROX_K = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   O,
    output logic                 O_mode,
    output logic [15:0]          done_cnt
);
    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] APPROX_MASK = {WIDTH{1'b1}} << APPROX_K;

    logic [STAGES-1:0] stage_vld;
    logic [PW-1:0]     stage_dat [STAGES];
    logic              stage_mode [STAGES];

    logic              stall;
    logic [WIDTH-1:0]  a_op;
    logic [WIDTH-1:0]  b_op;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     prod;

    assign out_valid = stage_vld[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign O         = stage_dat[STAGES-1];
    assign O_mode    = stage_mode[STAGES-1];

    // Clearing the low bits of a two's-complement value floors it to a multiple of 2^APPROX_K.
    always_comb begin
        a_op  = mode ? (A & APPROX_MASK) : A;
        b_op  = mode ? (B & APPROX_MASK) : B;
        a_ext = {{WIDTH{a_op[WIDTH-1]}}, a_op};
        b_ext = {{WIDTH{b_op[WIDTH-1]}}, b_op};
        prod  = a_ext * b_ext;
    end

    // Data only moves behind a valid beat, so the output holds its last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_dat[s]  <= '0;
                stage_mode[s] <= 1'b0;
            end
        end else if (!stall) begin
            stage_vld[0] <= in_valid;
            if (in_valid) begin
                stage_dat[0]  <= prod;
                stage_mode[0] <= mode;
            end
            for (int s = 1; s < STAGES; s++) begin
                stage_vld[s] <= stage_vld[s-1];
                if (stage_vld[s-1]) begin
                    stage_dat[s]  <= stage_dat[s-1];
                    stage_mode[s] <= stage_mode[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mul_ns_pipe.sv
module tb_mul_ns_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] O;
    logic        O_mode;
    logic [15:0] done_cnt;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [15:0] exp_cnt = 16'h0;

    mul_ns_pipe #(.WIDTH(8), .STAGES(2), .APPROX_K(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .O(O), .O_mode(O_mode), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // Single transaction: present at one negedge, expect the result two cycles later.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic m,
                           input logic [15:0] exp_o, input string name);
        @(negedge clk);
        A = a; B = b; mode = m; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL %s in_ready got %b exp 1", name, in_ready);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL %s early out_valid got %b exp 0", name, out_valid);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || O !== exp_o || O_mode !== m)
            $display("FAIL %s result got v=%b O=%h m=%b exp v=1 O=%h m=%b",
                     name, out_valid, O, O_mode, exp_o, m);
        else pass_cnt++;
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || done_cnt !== exp_cnt || O !== exp_o)
            $display("FAIL %s after got v=%b cnt=%h O=%h exp v=0 cnt=%h O=%h",
                     name, out_valid, done_cnt, O, exp_cnt, exp_o);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; A = 8'h03; B = 8'h03; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        exp_cnt = 16'h0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || O !== 16'h0 || O_mode !== 1'b0 || done_cnt !== 16'h0)
            $display("FAIL reset_state got v=%b rdy=%b O=%h m=%b cnt=%h exp 0 1 0000 0 0000",
                     out_valid, in_ready, O, O_mode, done_cnt);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL reset_beat_dropped cyc %0d out_valid got %b exp 0", i, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_idle_toggle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = i[0];
        end
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || done_cnt !== exp_cnt)
            $display("FAIL idle_toggle got v=%b cnt=%h exp v=0 cnt=%h", out_valid, done_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_modes();
        run_one(8'hFD, 8'h05, 1'b0, 16'hFFF1, "exact_neg");
        run_one(8'h07, 8'h06, 1'b1, 16'h0010, "approx_pos");
        run_one(8'hFD, 8'h05, 1'b1, 16'hFFF0, "approx_neg");
        run_one(8'h80, 8'h80, 1'b0, 16'h4000, "min_x_min");
        run_one(8'h80, 8'h7F, 1'b0, 16'hC080, "min_x_max");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta [3] = '{8'hFD, 8'hFD, 8'h07};
        logic [7:0]  tb [3] = '{8'h05, 8'h05, 8'h06};
        logic        tm [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] te [3] = '{16'hFFF1, 16'hFFF0, 16'h0010};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) begin
                A = ta[i]; B = tb[i]; mode = tm[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i >= 2) begin
                total_cnt++;
                if (out_valid !== 1'b1 || O !== te[i-2] || O_mode !== tm[i-2])
                    $display("FAIL b2b beat %0d got v=%b O=%h m=%b exp v=1 O=%h m=%b",
                             i - 2, out_valid, O, O_mode, te[i-2], tm[i-2]);
                else pass_cnt++;
                exp_cnt = exp_cnt + 16'd1;
            end
        end
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || done_cnt !== exp_cnt)
            $display("FAIL b2b_end got v=%b cnt=%h exp v=0 cnt=%h", out_valid, done_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0]  ta [4] = '{8'h01, 8'h02, 8'hFF, 8'h80};
        logic [7:0]  tb [4] = '{8'h01, 8'h03, 8'hFE, 8'h7F};
        logic [15:0] te [4] = '{16'h0001, 16'h0006, 16'h0002, 16'hC080};
        logic [15:0] got [$];
        int k = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            if (k < 4) begin
                A = ta[k]; B = tb[k]; mode = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 4) begin
                total_cnt++;
                if (in_ready !== 1'b0 || k != 2 || out_valid !== 1'b1 || O !== te[0])
                    $display("FAIL bp_stall got rdy=%b accepted=%0d v=%b O=%h exp rdy=0 accepted=2 v=1 O=%h",
                             in_ready, k, out_valid, O, te[0]);
                else pass_cnt++;
            end
            if (in_valid && in_ready) k++;
            if (out_valid && out_ready) got.push_back(O);
        end
        exp_cnt = exp_cnt + 16'd4;
        total_cnt++;
        if (got.size() != 4)
            $display("FAIL bp_count got %0d results exp 4", got.size());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (i >= got.size() || got[i] !== te[i])
                $display("FAIL bp_order idx %0d got %h exp %h", i, (i < got.size()) ? got[i] : 16'hxxxx, te[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cnt !== exp_cnt)
            $display("FAIL bp_done_cnt got %h exp %h", done_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            A = 8'h11 + 8'(i); B = 8'h02; mode = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 16'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if (out_valid !== 1'b0 || done_cnt !== 16'h0)
                $display("FAIL rst_mid cyc %0d got v=%b cnt=%h exp v=0 cnt=0000", i, out_valid, done_cnt);
            else pass_cnt++;
        end
        run_one(8'h03, 8'hFB, 1'b0, 16'hFFF1, "post_rst");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        A = 8'h01; B = 8'h01; mode = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        exp_cnt = 16'hFFFF;
        total_cnt++;
        if (done_cnt !== 16'hFFFF) $display("FAIL wrap_preload got %h exp ffff", done_cnt);
        else pass_cnt++;
        run_one(8'h02, 8'h02, 1'b1, 16'h0000, "wrap_beat");
        total_cnt++;
        if (done_cnt !== 16'h0000) $display("FAIL wrap got %h exp 0000", done_cnt);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; mode = 1'b0; out_ready = 1'b0;
        test_reset();
        test_idle_toggle();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
